// File: rtl/rotary_quad_decoder.sv
// Rotary encoder quadrature decoder: synchronize, debounce, and decode detents into event pulses.
// Optional detent position counter enabled by defining ROTARY_POSITION_EN.
module rotary_quad_decoder #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rotary_a,
    input  logic       rotary_b,
    output logic       rotary_event,
    output logic       rotary_left,
    output logic       rotary_error,
    output logic [7:0] position
);

    typedef enum logic {
        StLoad,
        StTrack
    } state_t;

    localparam logic [3:0]        CntMax = 4'(FILTER_CYCLES - 1);
    localparam logic signed [3:0] AccMax = 4'sd4;
    localparam logic signed [3:0] AccMin = -4'sd4;

    state_t            r_state;
    state_t            w_state_next;
    logic        [1:0] r_sync_a;
    logic        [1:0] r_sync_b;
    logic        [1:0] r_fill;
    logic              r_filt_a;
    logic              r_filt_b;
    logic        [3:0] r_cnt_a;
    logic        [3:0] r_cnt_b;
    logic        [1:0] r_q_prev;
    logic signed [3:0] r_acc;
    logic              r_event;
    logic              r_error;
    logic              r_left;

    logic              w_sa;
    logic              w_sb;
    logic              w_copy;
    logic              w_filt_a_d;
    logic              w_filt_b_d;
    logic        [3:0] w_cnt_a_d;
    logic        [3:0] w_cnt_b_d;
    logic        [1:0] w_q;
    logic        [1:0] w_q_prev_d;
    logic        [1:0] w_q_succ;
    logic              w_right;
    logic signed [3:0] w_acc_step;
    logic signed [3:0] w_acc_d;
    logic              w_event_d;
    logic              w_error_d;
    logic              w_left_d;

    assign w_sa = r_sync_a[1];
    assign w_sb = r_sync_b[1];
    assign w_q  = {r_filt_a, r_filt_b};

    // Filtered bits follow the synchronizers directly in LOAD and while the
    // synchronizers are still flushing their reset value, so the encoder's
    // resting position after reset is adopted without a spurious transition.
    always_comb begin
        w_state_next = r_state;
        w_copy       = 1'b0;
        unique case (r_state)
            StLoad: begin
                w_state_next = StTrack;
                w_copy       = 1'b1;
            end
            StTrack: begin
                w_state_next = StTrack;
                w_copy       = (r_fill != 2'd3);
            end
        endcase
    end

    always_comb begin
        w_filt_a_d = r_filt_a;
        w_filt_b_d = r_filt_b;
        w_cnt_a_d  = '0;
        w_cnt_b_d  = '0;
        if (w_copy) begin
            w_filt_a_d = w_sa;
            w_filt_b_d = w_sb;
        end else begin
            if (w_sa != r_filt_a) begin
                if (r_cnt_a == CntMax) w_filt_a_d = w_sa;
                else                   w_cnt_a_d  = r_cnt_a + 4'd1;
            end
            if (w_sb != r_filt_b) begin
                if (r_cnt_b == CntMax) w_filt_b_d = w_sb;
                else                   w_cnt_b_d  = r_cnt_b + 4'd1;
            end
        end
    end

    // Right-hand successor in the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
    always_comb begin
        w_q_succ = 2'b00;
        unique case (r_q_prev)
            2'b00: w_q_succ = 2'b01;
            2'b01: w_q_succ = 2'b11;
            2'b11: w_q_succ = 2'b10;
            2'b10: w_q_succ = 2'b00;
        endcase
    end

    assign w_right = (w_q == w_q_succ);

    always_comb begin
        w_acc_step = r_acc;
        if (w_right) w_acc_step = (r_acc == AccMax) ? AccMax : r_acc + 4'sd1;
        else         w_acc_step = (r_acc == AccMin) ? AccMin : r_acc - 4'sd1;
    end

    always_comb begin
        w_acc_d    = r_acc;
        w_event_d  = 1'b0;
        w_error_d  = 1'b0;
        w_left_d   = r_left;
        w_q_prev_d = w_copy ? {w_sa, w_sb} : w_q;
        if (!w_copy && (w_q != r_q_prev)) begin
            if (&(w_q ^ r_q_prev)) begin
                w_error_d = 1'b1;
                w_acc_d   = '0;
            end else if (w_q == 2'b00) begin
                w_acc_d = '0;
                if (w_acc_step == AccMax) begin
                    w_event_d = 1'b1;
                    w_left_d  = 1'b0;
                end else if (w_acc_step == AccMin) begin
                    w_event_d = 1'b1;
                    w_left_d  = 1'b1;
                end
            end else begin
                w_acc_d = w_acc_step;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StLoad;
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_fill   <= '0;
            r_filt_a <= 1'b0;
            r_filt_b <= 1'b0;
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_q_prev <= '0;
            r_acc    <= '0;
            r_event  <= 1'b0;
            r_error  <= 1'b0;
            r_left   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sync_a <= {r_sync_a[0], rotary_a};
            r_sync_b <= {r_sync_b[0], rotary_b};
            if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
            r_filt_a <= w_filt_a_d;
            r_filt_b <= w_filt_b_d;
            r_cnt_a  <= w_cnt_a_d;
            r_cnt_b  <= w_cnt_b_d;
            r_q_prev <= w_q_prev_d;
            r_acc    <= w_acc_d;
            r_event  <= w_event_d;
            r_error  <= w_error_d;
            r_left   <= w_left_d;
        end
    end

    assign rotary_event = r_event;
    assign rotary_error = r_error;
    assign rotary_left  = r_left;

`ifdef ROTARY_POSITION_EN
    logic [7:0] r_pos;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pos <= 8'h00;
        end else if (w_event_d) begin
            r_pos <= w_left_d ? r_pos - 8'd1 : r_pos + 8'd1;
        end
    end

    assign position = r_pos;
`else
    assign position = 8'h00;
`endif

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Scoreboard bench for rotary_quad_decoder: directed encoder sequences push expected pulses,
// a negedge monitor pops and checks kind, direction, position and arrival cycle.
module tb_rotary_quad_decoder;

    localparam int unsigned FC  = 4;
    localparam int          LAT = FC + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rotary_a = 1'b0;
    logic       rotary_b = 1'b0;
    logic       rotary_event;
    logic       rotary_left;
    logic       rotary_error;
    logic [7:0] position;

    rotary_quad_decoder #(.FILTER_CYCLES(FC)) dut (
        .clk         (clk),
        .reset       (reset),
        .rotary_a    (rotary_a),
        .rotary_b    (rotary_b),
        .rotary_event(rotary_event),
        .rotary_left (rotary_left),
        .rotary_error(rotary_error),
        .position    (position)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         err;
        bit         left;
        logic [7:0] pos;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] exp_pos = 8'h00;
    bit         last_left = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (reset && (rotary_event || rotary_error)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: ev=%0b err=%0b cyc=%0d, required no pulse",
                         rotary_event, rotary_error, cyc);
            end else begin
                e = sb.pop_front();
                if (rotary_error !== e.err || rotary_event !== !e.err || rotary_left !== e.left ||
                    position !== e.pos || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL pulse: ev=%0b err=%0b left=%0b pos=%0h cyc=%0d required ev=%0b err=%0b left=%0b pos=%0h cyc=%0d",
                             rotary_event, rotary_error, rotary_left, position, cyc,
                             !e.err, e.err, e.left, e.pos, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic drive(input logic a, input logic b, input int hold);
        rotary_a = a;
        rotary_b = b;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    // Call immediately before driving the change that completes a detent.
    task automatic expect_event(input bit left);
        exp_t e;
`ifdef ROTARY_POSITION_EN
        exp_pos = left ? exp_pos - 8'd1 : exp_pos + 8'd1;
`endif
        last_left = left;
        e.err = 1'b0;
        e.left = left;
        e.pos = exp_pos;
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic expect_error();
        exp_t e;
        e.err = 1'b1;
        e.left = last_left;
        e.pos = exp_pos;
        e.cyc = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic a, input logic b);
        reset = 1'b0;
        rotary_a = a;
        rotary_b = b;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {21'h0, rotary_event, rotary_error, rotary_left, position}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_pos = 8'h00;
        last_left = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_pending"}, sb.size(), 0);
        check({name, "_left_pos"}, {23'h0, rotary_left, position}, {23'h0, last_left, exp_pos});
    endtask

    initial begin
        // Idle after reset with encoder resting at 11
        do_reset(1'b1, 1'b1);
        drive(1'b1, 1'b1, 50);
        check_idle("idle11");

        // One right detent, latency checked by the scoreboard
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        expect_event(1'b0);
        drive(1'b0, 1'b0, 20);
        check_idle("right1");

        // Two left detents: position 00 -> FF -> FE
        do_reset(1'b0, 1'b0);
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'b0, 20);
            drive(1'b1, 1'b1, 20);
            drive(1'b0, 1'b1, 20);
            expect_event(1'b1);
            drive(1'b0, 1'b0, 20);
        end
        check_idle("left2");

        // Glitch filtering: 3-cycle pulses ignored, 4-cycle pulse completes a detent
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 20);
        check_idle("glitch3_a");
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 20);
        check_idle("glitch3_low");
        expect_event(1'b0);
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 20);
        check_idle("glitch4");

        // Right detent wrapping position FF -> 00
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        expect_event(1'b0);
        drive(1'b0, 1'b0, 20);
        check_idle("wrap");

        // Partial turn and return, then illegal double-bit jump
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 20);
        check_idle("partial");
        expect_error();
        drive(1'b1, 1'b1, 20);
        check_idle("jump");

        // Reset mid-detent discards the partial accumulation
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b1, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        do_reset(1'b1, 1'b0);
        drive(1'b0, 1'b0, 20);
        check_idle("midreset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
